// File: rtl/mips_fetch_pkg.sv
// Shared types and defaults for the IF-stage fetch sequencer.
package mips_fetch_pkg;

  localparam int unsigned FETCH_WIDTH = 32;
  localparam logic [FETCH_WIDTH-1:0] RESET_PC_DEF = 32'h0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    CANCEL = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// IF-stage sequencer: one outstanding instruction fetch, stall hold buffer,
// PC register enable/flush control and exception drain.
module pc_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter int unsigned         WIDTH    = FETCH_WIDTH,
  parameter logic [WIDTH-1:0]    RESET_PC = WIDTH'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_q_i,
  input  logic             stall_i,
  input  logic             exc_i,
  input  logic [WIDTH-1:0] exc_pc_i,
  output logic             inst_req_o,
  output logic [WIDTH-1:0] inst_addr_o,
  input  logic             inst_addr_ok_i,
  input  logic             inst_data_ok_i,
  input  logic [WIDTH-1:0] inst_rdata_i,
  output logic             pc_en_o,
  output logic             pc_flush_o,
  output logic [WIDTH-1:0] pc_newpc_o,
  output logic             if_valid_o,
  output logic [WIDTH-1:0] if_inst_o,
  output logic [WIDTH-1:0] if_pc_o
);

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic             latch_pc;
  logic             capture;
  logic             release_hold;

  // State register, fetch PC and hold buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch_pc) fetch_pc <= pc_q_i;
      if (capture) begin
        hold_data  <= inst_rdata_i;
        hold_valid <= 1'b1;
      end else if (release_hold || exc_i) begin
        hold_data  <= '0;
        hold_valid <= 1'b0;
      end
    end
  end

  // Next state and combinational handshake / PC-control outputs
  always_comb begin
    state_nxt    = state;
    latch_pc     = 1'b0;
    capture      = 1'b0;
    release_hold = 1'b0;
    inst_req_o   = 1'b0;
    inst_addr_o  = '0;
    pc_en_o      = 1'b0;
    pc_flush_o   = 1'b0;
    pc_newpc_o   = '0;
    if_valid_o   = 1'b0;
    if_inst_o    = '0;

    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        inst_req_o  = 1'b1;
        inst_addr_o = pc_q_i;
        if (inst_addr_ok_i) begin
          latch_pc  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (inst_data_ok_i) begin
          if (!stall_i) begin
            if_valid_o = 1'b1;
            if_inst_o  = inst_rdata_i;
            pc_en_o    = 1'b1;
            state_nxt  = REQ;
          end else begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall_i && hold_valid) begin
          if_valid_o   = 1'b1;
          if_inst_o    = hold_data;
          pc_en_o      = 1'b1;
          release_hold = 1'b1;
          state_nxt    = REQ;
        end
      end
      CANCEL: begin
        if (inst_data_ok_i) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides delivery; an accepted-but-unreturned fetch must drain
    if (exc_i) begin
      pc_flush_o   = 1'b1;
      pc_newpc_o   = exc_pc_i;
      if_valid_o   = 1'b0;
      if_inst_o    = '0;
      pc_en_o      = 1'b0;
      capture      = 1'b0;
      release_hold = 1'b0;
      case (state)
        REQ:     state_nxt = inst_addr_ok_i ? CANCEL : REQ;
        WAIT:    state_nxt = inst_data_ok_i ? REQ : CANCEL;
        CANCEL:  state_nxt = CANCEL;
        default: state_nxt = REQ;
      endcase
    end
  end

  assign if_pc_o = fetch_pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus random memory/stall/exception
// traffic, checked by a scoreboard of expected instruction PCs.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_q;
  logic        stall_i = 1'b0;
  logic        exc_i = 1'b0;
  logic [31:0] exc_pc_i = '0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i = 1'b0;
  logic        inst_data_ok_i = 1'b0;
  logic [31:0] inst_rdata_i = '0;
  logic        pc_en_o;
  logic        pc_flush_o;
  logic [31:0] pc_newpc_o;
  logic        if_valid_o;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  // Expected stream of delivered instruction PCs
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;

  // Memory-side model: at most one accepted fetch
  logic        outstanding = 1'b0;
  logic [31:0] out_addr = '0;

  logic        s_req, s_valid, s_en, s_flush;
  logic [31:0] s_addr, s_newpc, s_pc, s_inst;

  pc_fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_q_i(pc_q), .stall_i(stall_i), .exc_i(exc_i),
    .exc_pc_i(exc_pc_i), .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i(inst_rdata_i), .pc_en_o(pc_en_o), .pc_flush_o(pc_flush_o),
    .pc_newpc_o(pc_newpc_o), .if_valid_o(if_valid_o), .if_inst_o(if_inst_o),
    .if_pc_o(if_pc_o)
  );

  always #5 clk = ~clk;

  // The PC register this block controls
  always @(posedge clk) begin
    if (rst)             pc_q <= 32'h0;
    else if (pc_flush_o) pc_q <= pc_newpc_o;
    else if (pc_en_o)    pc_q <= pc_q + 32'd4;
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h0) ? 32'h24080001 : ((a ^ 32'h5A5A0000) + 32'h00000013);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic restart_q(input logic [31:0] target);
    exp_q.delete();
    exp_next = target;
  endtask

  task automatic topup_q();
    while (exp_q.size() < 4) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endtask

  // One clock: drive inputs, snapshot outputs at negedge, then advance the model
  task automatic cyc(input logic r, input logic aok, input logic dok, input logic st,
                     input logic ex, input logic [31:0] epc);
    @(posedge clk);
    #1;
    rst            = r;
    stall_i        = st;
    exc_i          = ex;
    exc_pc_i       = epc;
    inst_addr_ok_i = aok && inst_req_o;
    inst_data_ok_i = dok && outstanding;
    inst_rdata_i   = (dok && outstanding) ? mem_f(out_addr) : 32'h0;
    @(negedge clk);
    s_req = inst_req_o;   s_addr = inst_addr_o; s_valid = if_valid_o; s_en = pc_en_o;
    s_flush = pc_flush_o; s_newpc = pc_newpc_o; s_pc = if_pc_o;     s_inst = if_inst_o;
    #1;
    if (rst) begin
      outstanding = 1'b0;
      restart_q(32'h0);
    end else begin
      if (inst_data_ok_i) outstanding = 1'b0;
      if (s_req && inst_addr_ok_i) begin
        outstanding = 1'b1;
        out_addr    = s_addr;
      end
      if (exc_i) restart_q(exc_pc_i);
    end
    topup_q();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"}, 32'(s_req), 32'h0);
    chk({tag, "_addr"}, s_addr, 32'h0);
    chk({tag, "_valid"}, 32'(s_valid), 32'h0);
    chk({tag, "_en"}, 32'(s_en), 32'h0);
    chk({tag, "_flush"}, 32'(s_flush), 32'h0);
    chk({tag, "_newpc"}, s_newpc, 32'h0);
    chk({tag, "_inst"}, s_inst, 32'h0);
    chk({tag, "_pc"}, s_pc, 32'h0);
  endtask

  // Scoreboard monitor: checks every cycle against the expected stream
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("en_follows_delivery", 32'(pc_en_o), 32'(if_valid_o));
        chk("flush_follows_exc", 32'(pc_flush_o), 32'(exc_i));
        if (exc_i) begin
          chk("newpc", pc_newpc_o, exc_pc_i);
          chk("no_valid_on_exc", 32'(if_valid_o), 32'h0);
        end
        if (inst_req_o) chk("req_while_outstanding", 32'(outstanding), 32'h0);
        if (inst_req_o && inst_addr_ok_i) begin
          if (exp_q.size() == 0) chk("req_addr_queue_empty", inst_addr_o, 32'hxxxxxxxx);
          else chk("req_addr", inst_addr_o, exp_q[0]);
        end
        if (if_valid_o) begin
          chk("deliver_while_stalled", 32'(stall_i), 32'h0);
          if (exp_q.size() == 0) chk("deliver_queue_empty", if_pc_o, 32'hxxxxxxxx);
          else begin
            e = exp_q.pop_front();
            chk("deliver_pc", if_pc_o, e);
            chk("deliver_inst", if_inst_o, mem_f(e));
            n_deliv++;
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios, then random traffic
  initial begin
    restart_q(32'h0);
    topup_q();

    // Reset, then IDLE with everything quiet
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_idle("reset");

    // Zero-wait fetch of PC 0
    cyc(0, 1, 0, 0, 0, 0);
    chk("zw_req", 32'(s_req), 32'h1);
    chk("zw_addr", s_addr, 32'h0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("zw_valid", 32'(s_valid), 32'h1);
    chk("zw_en", 32'(s_en), 32'h1);
    chk("zw_pc", s_pc, 32'h0);
    chk("zw_inst", s_inst, 32'h24080001);

    // addr_ok after 3 cycles, data_ok 2 more later
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("slow_req_held", 32'(s_req), 32'h1);
      chk("slow_addr_stable", s_addr, 32'h4);
    end
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("slow_no_valid", 32'(s_valid), 32'h0);
      chk("slow_no_en", 32'(s_en), 32'h0);
    end
    cyc(0, 0, 1, 0, 0, 0);
    chk("slow_valid", 32'(s_valid), 32'h1);
    chk("slow_en", 32'(s_en), 32'h1);
    chk("slow_pc", s_pc, 32'h4);

    // data_ok under a 4-cycle stall
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("stall_capture_no_valid", 32'(s_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      chk("hold_no_valid", 32'(s_valid), 32'h0);
      chk("hold_no_req", 32'(s_req), 32'h0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("hold_release_valid", 32'(s_valid), 32'h1);
    chk("hold_release_en", 32'(s_en), 32'h1);
    chk("hold_release_pc", s_pc, 32'h8);
    chk("hold_release_inst", s_inst, mem_f(32'h8));

    // Exception during WAIT: drain, then fetch the vector
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hBFC00380);
    chk("exc_wait_flush", 32'(s_flush), 32'h1);
    chk("exc_wait_newpc", s_newpc, 32'hBFC00380);
    cyc(0, 0, 0, 0, 0, 0);
    chk("cancel_no_req", 32'(s_req), 32'h0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("cancel_drop_valid", 32'(s_valid), 32'h0);
    chk("cancel_drop_en", 32'(s_en), 32'h0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("vector_req", 32'(s_req), 32'h1);
    chk("vector_addr", s_addr, 32'hBFC00380);
    cyc(0, 0, 1, 0, 0, 0);
    chk("vector_pc", s_pc, 32'hBFC00380);

    // Exception coinciding with data_ok and no stall
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 32'h00001000);
    chk("exc_dok_valid", 32'(s_valid), 32'h0);
    chk("exc_dok_en", 32'(s_en), 32'h0);
    chk("exc_dok_flush", 32'(s_flush), 32'h1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("exc_dok_next_addr", s_addr, 32'h00001000);

    // Reset during WAIT restarts at 0
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_idle("rst_wait");
    cyc(0, 1, 0, 0, 0, 0);
    chk("rst_restart_addr", s_addr, 32'h0);
    chk("rst_restart_req", 32'(s_req), 32'h1);

    // Random traffic
    n_deliv = 0;
    for (int i = 0; i < 4000; i++) begin
      logic r, ex;
      r  = ($urandom_range(0, 399) == 0);
      ex = !r && ($urandom_range(0, 29) == 0);
      cyc(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 9) < 3), ex, {$urandom_range(0, 32'h3FFFFFFF), 2'b00});
    end
    cyc(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (n_deliv < 100) begin
      n_fail++;
      $display("FAIL random_progress: got %0d deliveries expected at least 100", n_deliv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
